// File: rtl/product_accumulator.sv
// product_accumulator: sums BLOCK_LEN consecutive unsigned products into one
// saturating result. Products arrive on a valid/ready input handshake. Each
// block result, with a sticky per-block overflow flag, leaves on a second
// valid/ready handshake.
module product_accumulator #(
   parameter int P_W       = 8,
   parameter int ACC_W     = 12,
   parameter int BLOCK_LEN = 4,
   localparam int IDX_W    = $clog2(BLOCK_LEN + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic [P_W-1:0]   p_i,
   input  logic             p_valid_i,
   output logic             p_ready_o,
   output logic [ACC_W-1:0] sum_o,
   output logic             sum_ovf_o,
   output logic             sum_valid_o,
   input  logic             sum_ready_i,
   output logic [IDX_W-1:0] idx_o
);

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               sat_q, sat_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic [ACC_W:0]     t;
   logic               sat_nxt;
   logic [ACC_W-1:0]   acc_nxt;
   logic               last;

   // The add is one bit wider than the accumulator so its carry shows the overflow.
   // Once the block has saturated it stays at all-ones until the block ends.
   always_comb begin
      accept  = p_valid_i & (state_q == ACC);
      t       = {1'b0, acc_q} + {{(ACC_W + 1 - P_W){1'b0}}, p_i};
      sat_nxt = sat_q | t[ACC_W];
      acc_nxt = sat_nxt ? {ACC_W{1'b1}} : t[ACC_W-1:0];
      last    = (idx_q == IDX_W'(BLOCK_LEN - 1));
   end

   // Next state. clear has priority over accept and sum_ready.
   // sum is never cleared. It keeps the last result after the hand-off.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      sat_d   = sat_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      if (clear_i) begin
         state_d = ACC;
         acc_d   = '0;
         idx_d   = '0;
         sat_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (accept) begin
                  if (last) begin
                     sum_d   = acc_nxt;
                     ovf_d   = sat_nxt;
                     acc_d   = '0;
                     idx_d   = '0;
                     sat_d   = 1'b0;
                     state_d = HOLD;
                  end else begin
                     acc_d = acc_nxt;
                     idx_d = idx_q + IDX_W'(1);
                     sat_d = sat_nxt;
                  end
               end
            end
            HOLD: begin
               if (sum_ready_i) state_d = ACC;
            end
            default: state_d = ACC;
         endcase
      end
   end

   // State registers. Reset is asynchronous, so any pending result is dropped at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACC;
         acc_q   <= '0;
         idx_q   <= '0;
         sat_q   <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         sat_q   <= sat_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   // Both handshake flags are decoded only from the state register.
   // There is no combinational path from sum_ready to p_ready.
   always_comb begin
      p_ready_o   = (state_q == ACC);
      sum_valid_o = (state_q == HOLD);
      sum_o       = sum_q;
      sum_ovf_o   = ovf_q;
      idx_o       = idx_q;
   end

endmodule
